// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory arbiter: widths, port ids and priority modes.
package data_mem_pkg;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int HOLD_W     = 4;
  localparam int PORT_CPU   = 0;
  localparam int PORT_DMA   = 1;
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/data_mem_arb_pick.sv
// Combinational winner selection for the two-port data memory arbiter.
module data_mem_arb_pick
  import data_mem_pkg::*;
#(
  parameter int PRIORITY_MODE = PRIO_RR,
  parameter int MAX_HOLD      = 4
) (
  input  logic [1:0]        req_i,
  input  logic [1:0]        lock_i,
  input  logic              last_grant_i,
  input  logic [HOLD_W-1:0] hold_cnt_i,
  output logic              winner_o,
  output logic              any_grant_o
);

  logic owner_lock;
  logic owner_keep;

  // Owner's lock only matters when both ports contend; once its hold budget is
  // spent the other port is forced in, even under fixed priority.
  assign owner_lock = lock_i[last_grant_i];
  assign owner_keep = owner_lock && (hold_cnt_i < HOLD_W'(MAX_HOLD));

  always_comb begin
    any_grant_o = |req_i;
    winner_o    = last_grant_i;
    unique case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      2'b11: begin
        if (owner_keep)                    winner_o = last_grant_i;
        else if (owner_lock)               winner_o = ~last_grant_i;
        else if (PRIORITY_MODE == PRIO_FIXED) winner_o = 1'b0;
        else                               winner_o = ~last_grant_i;
      end
      default: winner_o = last_grant_i;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU LSU (port 0) and a
// secondary master (port 1); combinational grant, read data one cycle later.
module data_mem_arbiter #(
  parameter int ADDR_W        = data_mem_pkg::ADDR_W,
  parameter int DATA_W        = data_mem_pkg::DATA_W,
  parameter int PRIORITY_MODE = data_mem_pkg::PRIO_RR,
  parameter int MAX_HOLD      = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_MW,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import data_mem_pkg::*;

  logic [1:0]             req, we, lock;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;

  logic                   last_grant_q, last_grant_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic winner, any_grant, xfer, addr_sel;

  assign req   = {req1, req0};
  assign we    = {we1, we0};
  assign lock  = {lock1, lock0};
  assign addr  = {addr1, addr0};
  assign wdata = {wdata1, wdata0};

  data_mem_arb_pick #(
    .PRIORITY_MODE (PRIORITY_MODE),
    .MAX_HOLD      (MAX_HOLD)
  ) u_pick (
    .req_i        (req),
    .lock_i       (lock),
    .last_grant_i (last_grant_q),
    .hold_cnt_i   (hold_cnt_q),
    .winner_o     (winner),
    .any_grant_o  (any_grant)
  );

  // Reset masks every grant so no memory write can slip through.
  assign xfer     = any_grant & ~reset;
  assign gnt0     = xfer & ~winner;
  assign gnt1     = xfer &  winner;
  assign addr_sel = any_grant ? winner : last_grant_q;

  assign mem_addr  = addr[addr_sel];
  assign mem_wdata = wdata[winner];
  assign mem_MW    = xfer & we[winner];

  always_comb begin
    last_grant_d = last_grant_q;
    hold_cnt_d   = '0;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    if (xfer) begin
      last_grant_d = winner;
      if (winner == last_grant_q)
        hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
      else
        hold_cnt_d = HOLD_W'(1);
      if (!we[winner]) begin
        rvalid_d[winner] = 1'b1;
        rdata_d[winner]  = mem_rdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      hold_cnt_q   <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  // A response captured just before reset rises is dropped, not delivered.
  assign rvalid0 = rvalid_q[0] & ~reset;
  assign rvalid1 = rvalid_q[1] & ~reset;
  assign rdata0  = rdata_q[0];
  assign rdata1  = rdata_q[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority instance on shared stimulus.
module tb_data_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          CLK, reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          r_gnt0, r_gnt1, r_rv0, r_rv1, r_mw;
  logic [DW-1:0] r_rd0, r_rd1, r_mwd, r_mrd;
  logic [AW-1:0] r_maddr;
  logic          f_gnt0, f_gnt1, f_rv0, f_rv1, f_mw;
  logic [DW-1:0] f_rd0, f_rd1, f_mwd, f_mrd;
  logic [AW-1:0] f_maddr;

  logic [DW-1:0] mem_r [64];
  logic [DW-1:0] mem_f [64];

  int nchk = 0;
  int nerr = 0;

  data_mem_arbiter #(.PRIORITY_MODE(0), .MAX_HOLD(4)) u_rr (
    .CLK(CLK), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(r_gnt0), .gnt1(r_gnt1),
    .rvalid0(r_rv0), .rvalid1(r_rv1), .rdata0(r_rd0), .rdata1(r_rd1),
    .mem_addr(r_maddr), .mem_MW(r_mw), .mem_wdata(r_mwd), .mem_rdata(r_mrd));

  data_mem_arbiter #(.PRIORITY_MODE(1), .MAX_HOLD(4)) u_fx (
    .CLK(CLK), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(f_gnt0), .gnt1(f_gnt1),
    .rvalid0(f_rv0), .rvalid1(f_rv1), .rdata0(f_rd0), .rdata1(f_rd1),
    .mem_addr(f_maddr), .mem_MW(f_mw), .mem_wdata(f_mwd), .mem_rdata(f_mrd));

  // Memory models: asynchronous read, write on posedge when MW.
  assign r_mrd = mem_r[r_maddr];
  assign f_mrd = mem_f[f_maddr];
  always @(posedge CLK) begin
    if (r_mw) mem_r[r_maddr] <= r_mwd;
    if (f_mw) mem_f[f_maddr] <= f_mwd;
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [1:0] lock_seq [6];
    lock_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 64; i++) begin
      mem_r[i] = DW'(i);
      mem_f[i] = DW'(i);
    end
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge CLK);

    // Reset: requests present but masked
    req0 = 1; we0 = 1; addr0 = 5; req1 = 1; we1 = 1; #1;
    chk("rst_gnt", 32'({r_gnt1, r_gnt0}), 32'd0);
    chk("rst_mw", 32'(r_mw), 32'd0);
    chk("rst_rvalid", 32'({r_rv1, r_rv0}), 32'd0);
    chk("rst_rdata0", r_rd0, 32'd0);

    // Single read, addr 5
    @(negedge CLK); reset = 0; req1 = 0; we1 = 0; we0 = 0; #1;
    chk("rd5_gnt", 32'({r_gnt1, r_gnt0}), 32'b01);
    chk("rd5_mw", 32'(r_mw), 32'd0);
    @(negedge CLK); req0 = 0; #1;
    chk("rd5_rvalid", 32'({r_rv1, r_rv0}), 32'b01);
    chk("rd5_rdata", r_rd0, 32'd5);
    @(negedge CLK); #1;
    chk("rd5_rvalid_drop", 32'(r_rv0), 32'd0);
    chk("rd5_rdata_hold", r_rd0, 32'd5);

    // Round-robin back-to-back reads after a fresh reset
    @(negedge CLK); reset = 1;
    @(negedge CLK); reset = 0; req0 = 1; req1 = 1; addr0 = 1; addr1 = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt", 32'({r_gnt1, r_gnt0}), (i % 2) ? 32'b10 : 32'b01);
      if (i > 0) begin
        chk("rr_rvalid", 32'({r_rv1, r_rv0}), ((i - 1) % 2) ? 32'b10 : 32'b01);
        chk("rr_rdata", ((i - 1) % 2) ? r_rd1 : r_rd0, ((i - 1) % 2) ? 32'd2 : 32'd1);
      end
      @(negedge CLK);
    end
    req0 = 0; req1 = 0; #1;
    chk("rr_last_rvalid", 32'({r_rv1, r_rv0}), 32'b10);
    chk("rr_last_rdata", r_rd1, 32'd2);

    // Port 1 write, then port 0 read-back
    @(negedge CLK); req1 = 1; we1 = 1; addr1 = 9; wdata1 = 32'hDEADBEEF; #1;
    chk("wr_gnt", 32'({r_gnt1, r_gnt0}), 32'b10);
    chk("wr_mw", 32'(r_mw), 32'd1);
    chk("wr_addr", 32'(r_maddr), 32'd9);
    chk("wr_wdata", r_mwd, 32'hDEADBEEF);
    @(negedge CLK); req1 = 0; we1 = 0; req0 = 1; addr0 = 9; #1;
    chk("rb_gnt", 32'({r_gnt1, r_gnt0}), 32'b01);
    chk("rb_mw", 32'(r_mw), 32'd0);
    @(negedge CLK); req0 = 0; #1;
    chk("rb_rvalid", 32'({r_rv1, r_rv0}), 32'b01);
    chk("rb_rdata", r_rd0, 32'hDEADBEEF);

    // Lock burst: 4 grants to port 0, then port 1, then round-robin back to 0
    @(negedge CLK); req0 = 1; req1 = 1; lock0 = 1; addr0 = 1; addr1 = 2;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("lock_gnt", 32'({r_gnt1, r_gnt0}), 32'(lock_seq[i]));
      @(negedge CLK);
    end

    // Fixed priority: port 1 starves until req0 drops
    req0 = 0; req1 = 0; lock0 = 0;
    @(negedge CLK); req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fx_gnt", 32'({f_gnt1, f_gnt0}), 32'b01);
      @(negedge CLK);
    end
    req0 = 0; #1;
    chk("fx_gnt_drop", 32'({f_gnt1, f_gnt0}), 32'b10);

    // Reset with a read outstanding
    @(negedge CLK); req0 = 1; we0 = 0; addr0 = 3; req1 = 0; #1;
    chk("rr_out_gnt", 32'({r_gnt1, r_gnt0}), 32'b01);
    @(negedge CLK); reset = 1; req1 = 1; we0 = 1; we1 = 1;
    addr0 = 7; addr1 = 7; wdata0 = 32'h0BAD0BAD; wdata1 = 32'h0BAD0BAD; #1;
    chk("rst_out_rvalid", 32'({r_rv1, r_rv0}), 32'd0);
    chk("rst_out_gnt", 32'({r_gnt1, r_gnt0}), 32'd0);
    chk("rst_out_mw", 32'(r_mw), 32'd0);
    @(negedge CLK); reset = 0; we0 = 0; we1 = 0; #1;
    chk("post_rst_tie", 32'({r_gnt1, r_gnt0}), 32'b01);
    @(negedge CLK); req0 = 0; req1 = 0; #1;
    chk("post_rst_rvalid", 32'({r_rv1, r_rv0}), 32'b01);
    chk("post_rst_rdata", r_rd0, 32'd7);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
